tilelink_ul_master: RTL



---
 rtl/tilelink_ul_pkg.sv | 39 +++
 rtl/tilelink_ul_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tilelink_ul_pkg.sv
// Shared TileLink-UL definitions: channel opcodes, master FSM states and
// helpers that shape A-channel requests from a command's size and address.
package tilelink_ul_pkg;

    localparam logic [2:0] TL_A_GET         = 3'd4;
    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;

    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_REJ
    } tl_state_e;

    function automatic logic [3:0] tl_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << addr_lo;
            3'd1:    m = 4'b0011 << {addr_lo[1], 1'b0};
            default: m = 4'hF;
        endcase
        return m;
    endfunction

    // The data bus is one word wide, so anything up to a word is a single beat.
    function automatic logic [4:0] tl_beats(input logic [2:0] size);
        logic [4:0] b;
        if (size <= 3'd2)
            b = 5'd1;
        else
            b = 5'd1 << (size - 3'd2);
        return b;
    endfunction

endpackage

// File: rtl/tilelink_ul_master.sv
// Single-outstanding TileLink-UL initiator: one command becomes one Get or
// PutFullData on channel A, and every D beat is checked and forwarded as a response.
module tilelink_ul_master
    import tilelink_ul_pkg::*;
#(
    parameter int SOURCE_ID = 0,
    parameter int MAX_SIZE  = 6,
    parameter int TIMEOUT   = 64
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_data,

    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        rsp_last,

    output logic        a_valid,
    input  logic        a_ready,
    output logic [2:0]  a_opcode,
    output logic [2:0]  a_param,
    output logic [2:0]  a_size,
    output logic [4:0]  a_source,
    output logic [31:0] a_address,
    output logic [3:0]  a_mask,
    output logic [31:0] a_data,

    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_opcode,
    input  logic [1:0]  d_param,
    input  logic [2:0]  d_size,
    input  logic [4:0]  d_source,
    input  logic        d_sink,
    input  logic [31:0] d_data,
    input  logic        d_error,

    output logic        timeout_flag,
    output logic        proto_err
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [4:0]      SRC       = SOURCE_ID[4:0];
    localparam logic [2:0]      MAX_SZ    = MAX_SIZE[2:0];
    localparam logic [TW-1:0]   TMO_LIMIT = TW'(TIMEOUT);

    tl_state_e       state;
    logic [3:0]      beat_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [31:0]     align_mask;
    logic            cmd_illegal;
    logic            check_fail;
    logic            d_fire;
    logic            unused_d;

    assign a_param  = 3'd0;
    assign a_source = SRC;
    assign d_fire   = d_valid && d_ready;
    assign unused_d = ^{d_param, d_sink};

    always_comb begin
        align_mask  = (32'd1 << cmd_size) - 32'd1;
        cmd_illegal = (cmd_size > MAX_SZ)
                   || (cmd_write && (cmd_size > 3'd2))
                   || ((cmd_addr & align_mask) != 32'd0);
    end

    // The outstanding op's kind is recovered from the held A opcode.
    always_comb begin
        check_fail = (d_source != SRC)
                  || (d_size != a_size)
                  || (d_opcode != ((a_opcode == TL_A_PUT_FULL) ? TL_D_ACCESS_ACK
                                                                : TL_D_ACCESS_ACK_DATA));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b0;
            d_ready      <= 1'b0;
            a_valid      <= 1'b0;
            a_opcode     <= 3'd0;
            a_size       <= 3'd0;
            a_address    <= 32'd0;
            a_mask       <= 4'd0;
            a_data       <= 32'd0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 32'd0;
            rsp_error    <= 1'b0;
            rsp_last     <= 1'b0;
            beat_cnt     <= 4'd0;
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            d_ready   <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_last  <= 1'b0;

            if ((state != ST_RESP) && d_fire)
                proto_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        a_opcode  <= cmd_write ? TL_A_PUT_FULL : TL_A_GET;
                        a_size    <= cmd_size;
                        a_address <= cmd_addr;
                        a_mask    <= tl_mask(cmd_size, cmd_addr[1:0]);
                        a_data    <= cmd_data;
                        if (cmd_illegal) begin
                            state <= ST_REJ;
                        end else begin
                            state   <= ST_REQ;
                            a_valid <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    if (a_ready) begin
                        a_valid  <= 1'b0;
                        state    <= ST_RESP;
                        beat_cnt <= 4'(tl_beats(a_size) - 5'd1);
                        tmo_cnt  <= '0;
                    end
                end

                // A beat arriving on the expiry cycle wins over the timeout.
                ST_RESP: begin
                    if (d_fire) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= d_data;
                        rsp_error <= d_error || check_fail;
                        tmo_cnt   <= '0;
                        if (check_fail)
                            proto_err <= 1'b1;
                        if (beat_cnt == 4'd0) begin
                            rsp_last  <= 1'b1;
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt - 4'd1;
                        end
                    end else if ((tmo_cnt + TW'(1)) == TMO_LIMIT) begin
                        rsp_valid    <= 1'b1;
                        rsp_data     <= 32'd0;
                        rsp_error    <= 1'b1;
                        rsp_last     <= 1'b1;
                        timeout_flag <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= ST_IDLE;
                        cmd_ready    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_REJ: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= 32'd0;
                    rsp_error <= 1'b1;
                    rsp_last  <= 1'b1;
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
